// File: rtl/in128_out1536_pack.sv
// in128_out1536_pack: packs up to 12 128-bit AXI-Stream beats into one 1536-bit word,
// closing early on tlast with zero-filled upper lanes and a one-hot lane tlast.
module in128_out1536_pack #(
  parameter int IN_W  = 128,
  parameter int LANES = 12,
  localparam int OUT_W = IN_W * LANES,
  localparam int LW    = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [LANES-1:0]  m_axis_tlast
);
  typedef enum logic {FILL, PEND} state_t;
  state_t            state_q, state_d;
  logic [LW-1:0]     lane_cnt_q, lane_cnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d, acc_w, out_data_q, out_data_d;
  logic [LANES-1:0]  acc_last_q, acc_last_d, last_w, out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic              ofree, last_lane, acc_en, take, closing;
  assign ofree         = ~out_valid_q | m_axis_tready;
  assign last_lane     = lane_cnt_q == LW'(LANES - 1);
  assign s_axis_tready = (state_q == FILL) & (ofree | ~last_lane);
  assign acc_en        = s_axis_tvalid & s_axis_tready;
  assign take          = out_valid_q & m_axis_tready;
  assign closing       = last_lane | s_axis_tlast;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;
  always_comb begin
    acc_w = acc_q;
    acc_w[lane_cnt_q*IN_W +: IN_W] = s_axis_tdata;
    last_w = acc_last_q | (LANES'(s_axis_tlast) << lane_cnt_q);
    state_d = state_q;
    lane_cnt_d = lane_cnt_q;
    acc_d = acc_q;
    acc_last_d = acc_last_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_valid_d = take ? 1'b0 : out_valid_q;
    if (state_q == PEND) begin
      if (ofree) begin
        out_data_d = acc_q;
        out_last_d = acc_last_q;
        out_valid_d = 1'b1;
        acc_d = '0;
        acc_last_d = '0;
        lane_cnt_d = '0;
        state_d = FILL;
      end
    end else if (acc_en) begin
      if (!closing) begin
        acc_d = acc_w;
        acc_last_d = last_w;
        lane_cnt_d = lane_cnt_q + 1'b1;
      end else if (ofree) begin
        out_data_d = acc_w;
        out_last_d = last_w;
        out_valid_d = 1'b1;
        acc_d = '0;
        acc_last_d = '0;
        lane_cnt_d = '0;
      end else begin
        // early tlast while the output is still held: park the word until it drains
        acc_d = acc_w;
        acc_last_d = last_w;
        state_d = PEND;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      lane_cnt_q <= '0;
      acc_q <= '0;
      acc_last_q <= '0;
      out_data_q <= '0;
      out_last_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_cnt_q <= lane_cnt_d;
      acc_q <= acc_d;
      acc_last_q <= acc_last_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_in128_out1536_pack.sv
// tb_in128_out1536_pack: directed scoreboard bench for the 128->1536 packer.
module tb_in128_out1536_pack;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [127:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [1535:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [11:0]   m_tlast;

  typedef struct {logic [1535:0] d; logic [11:0] l;} word_t;
  word_t         sb[$];
  int            vecs = 0, errs = 0, stalls = 0, cyc = 0;
  logic [1535:0] m_acc = '0;
  logic [11:0]   m_last = '0;
  int            m_lane = 0;

  in128_out1536_pack dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [1535:0] act, input logic [1535:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [127:0] d, input logic l);
    m_acc[m_lane*128 +: 128] = d;
    if (l) m_last[m_lane] = 1'b1;
    if (l || m_lane == 11) begin
      sb.push_back('{m_acc, m_last});
      m_acc = '0;
      m_last = '0;
      m_lane = 0;
    end else m_lane++;
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    bit done = 0;
    int n = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      if (s_tready) done = 1;
      else stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    if (done) model_accept(d, l);
    else begin
      vecs++;
      errs++;
      $display("FAIL send_timeout: beat %0h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_word: got %0h want none", m_tdata);
      end else begin
        word_t e;
        e = sb.pop_front();
        chk("word_data", m_tdata, e.d);
        chk("word_last", 1536'(m_tlast), 1536'(e.l));
      end
    end
  end

  initial begin
    int c0, s0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mvalid", 1536'(m_tvalid), 1536'(0));
    chk("rst_mdata", m_tdata, '0);
    chk("rst_mlast", 1536'(m_tlast), 1536'(0));
    chk("rst_sready", 1536'(s_tready), 1536'(1));
    @(posedge clk);
    #1;
    // T1: full word, lane i = i, no tlast
    for (int i = 0; i < 12; i++) send(128'(i), 1'b0);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t1_latency", 1536'(m_tvalid), 1536'(1));
    chk("t1_lane11", 1536'(m_tdata[1535:1408]), 1536'(11));
    chk("t1_last", 1536'(m_tlast), 1536'(0));
    @(posedge clk);
    #1;
    idle(2);
    // T2: early tlast at lane 4
    for (int i = 0; i < 5; i++) send(128'(8'hA0 + i), i == 4);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t2_last", 1536'(m_tlast), 1536'(12'h010));
    chk("t2_lane4", 1536'(m_tdata[639:512]), 1536'(8'hA4));
    chk("t2_zero", m_tdata[1535:640], '0);
    @(posedge clk);
    #1;
    idle(2);
    // T3: 36 back-to-back beats, no bubbles
    c0 = cyc;
    s0 = stalls;
    for (int k = 0; k < 36; k++) send({32'(k + 100), 64'h0123456789ABCDEF, 32'(k)}, 1'b0);
    chk("t3_cycles", 1536'(cyc - c0), 1536'(36));
    chk("t3_stalls", 1536'(stalls - s0), 1536'(0));
    idle(3);
    // T4: word held by m_tready=0; second word stalls at lane 11
    m_tready = 1'b0;
    for (int i = 0; i < 12; i++) send(128'(32'hAA00 + i), 1'b0);
    fork
      begin
        for (int i = 0; i < 12; i++) send(128'(32'hBB00 + i), 1'b0);
        s_tvalid = 1'b0;
      end
      begin
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("t4_sready_held", 1536'(s_tready), 1536'(0));
        chk("t4_mvalid_held", 1536'(m_tvalid), 1536'(1));
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    idle(3);
    // T5: tlast at lane 2 while output held -> PEND
    m_tready = 1'b0;
    for (int i = 0; i < 12; i++) send(128'(32'hCC00 + i), 1'b0);
    for (int i = 0; i < 3; i++) send(128'(32'hDD00 + i), i == 2);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t5_pend_sready", 1536'(s_tready), 1536'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_still_pend", 1536'(s_tready), 1536'(0));
    @(posedge clk);
    #1 m_tready = 1'b1;
    @(negedge clk);
    chk("t5_held_valid", 1536'(m_tlast), 1536'(0));
    @(negedge clk);
    chk("t5_pend_valid", 1536'(m_tvalid), 1536'(1));
    chk("t5_pend_last", 1536'(m_tlast), 1536'(12'h004));
    @(negedge clk);
    chk("t5_fill_sready", 1536'(s_tready), 1536'(1));
    @(posedge clk);
    #1;
    idle(2);
    // T6: reset after 7 beats discards the partial word
    for (int i = 0; i < 7; i++) send(128'(32'hEE00 + i), 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    m_acc = '0;
    m_last = '0;
    m_lane = 0;
    @(negedge clk);
    chk("t6_rst_mvalid", 1536'(m_tvalid), 1536'(0));
    chk("t6_rst_mdata", m_tdata, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 12; i++) send(128'(32'hFF00 + i), 1'b0);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_lane0", 1536'(m_tdata[127:0]), 1536'(32'hFF00));
    chk("t6_lane7", 1536'(m_tdata[1023:896]), 1536'(32'hFF07));
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    chk("sb_empty", 1536'(sb.size()), 1536'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
